// File: rtl/instr_sequencer.sv
// Program-memory reader: owns the PC, fetches 35-bit words from the async ROM, splits them into
// fields and issues them over valid/ready. Optional INSTR_SKIP_NOP_EN skips all-zero words in FETCH.

// Opcode codes normally come from CPU.vh; these apply only when it has not been preloaded.
`ifndef JMP
`define JMP 4'd4
`endif
`ifndef ATC
`define ATC 4'd5
`endif
`ifndef UNC
`define UNC 3'd0
`endif

module instr_sequencer #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_addr,
  input  logic [34:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  cmd,
  output logic [2:0]  op,
  output logic [1:0]  src_type,
  output logic [7:0]  src_val,
  output logic [1:0]  dst_type,
  output logic [7:0]  dst_val,
  output logic [7:0]  jmp_addr,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic [7:0]  pc
);

  typedef enum logic [1:0] {StFetch, StIssue, StWaitBr} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [34:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        skip_nop;
  logic        is_uncond;
  logic        is_cond;

`ifdef INSTR_SKIP_NOP_EN
  assign skip_nop = (rom_data == 35'd0);
`else
  assign skip_nop = 1'b0;
`endif

  assign cmd      = instr_q[34:31];
  assign op       = instr_q[30:28];
  assign src_type = instr_q[27:26];
  assign src_val  = instr_q[25:18];
  assign dst_type = instr_q[17:16];
  assign dst_val  = instr_q[15:8];
  assign jmp_addr = instr_q[7:0];

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;

  assign is_uncond = (cmd == `JMP) && (op == `UNC);
  assign is_cond   = ((cmd == `JMP) && !is_uncond) || (cmd == `ATC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      StFetch: begin
        if (skip_nop) begin
          pc_d = pc_q + 8'd1;
        end else begin
          instr_d = rom_data;
          valid_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (is_uncond) begin
            pc_d    = jmp_addr;
            state_d = StFetch;
          end else if (is_cond) begin
            state_d = StWaitBr;
          end else begin
            pc_d    = pc_q + 8'd1;
            state_d = StFetch;
          end
        end
      end
      StWaitBr: begin
        if (br_valid) begin
          pc_d    = br_taken ? jmp_addr : pc_q + 8'd1;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal expectations, then
// randomized ROM/handshake traffic compared every cycle against an instruction-level model.

`ifndef JMP
`define JMP 4'd4
`endif
`ifndef ATC
`define ATC 4'd5
`endif
`ifndef UNC
`define UNC 3'd0
`endif
`ifndef MOV
`define MOV 4'd1
`endif
`ifndef ACC
`define ACC 4'd2
`endif

module tb_instr_sequencer;

  localparam logic [7:0] ResetPc = 8'd0;
`ifdef INSTR_SKIP_NOP_EN
  localparam bit SkipNop = 1'b1;
`else
  localparam bit SkipNop = 1'b0;
`endif

  logic        clk, reset;
  logic [7:0]  rom_addr, pc;
  logic [34:0] rom_data;
  logic        instr_valid, instr_ready, br_valid, br_taken;
  logic [3:0]  cmd;
  logic [2:0]  op;
  logic [1:0]  src_type, dst_type;
  logic [7:0]  src_val, dst_val, jmp_addr;
  logic [34:0] fields;
  logic [34:0] rom [256];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  instr_sequencer #(.RESET_PC(ResetPc)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .cmd(cmd), .op(op),
    .src_type(src_type), .src_val(src_val), .dst_type(dst_type), .dst_val(dst_val),
    .jmp_addr(jmp_addr), .br_valid(br_valid), .br_taken(br_taken), .pc(pc)
  );

  assign rom_data = rom[rom_addr];
  assign fields   = {cmd, op, src_type, src_val, dst_type, dst_val, jmp_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] mk(input logic [3:0] c, input logic [2:0] o,
                                     input logic [1:0] st, input logic [7:0] sv,
                                     input logic [1:0] dt, input logic [7:0] dv,
                                     input logic [7:0] ja);
    return {c, o, st, sv, dt, dv, ja};
  endfunction

  function automatic bit uncond_jump(input logic [34:0] w);
    return (w[34:31] == `JMP) && (w[30:28] == `UNC);
  endfunction

  function automatic bit awaits_outcome(input logic [34:0] w);
    return ((w[34:31] == `JMP) && !uncond_jump(w)) || (w[34:31] == `ATC);
  endfunction

  // Instruction-level model: which word is held, whether it is on offer or awaiting an outcome.
  logic [7:0]  m_pc;
  logic [34:0] m_word;
  bit          m_offered, m_awaiting;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= ResetPc; m_word <= '0; m_offered <= 1'b0; m_awaiting <= 1'b0;
    end else if (m_offered) begin
      if (instr_ready) begin
        m_offered <= 1'b0;
        if (uncond_jump(m_word)) m_pc <= m_word[7:0];
        else if (awaits_outcome(m_word)) m_awaiting <= 1'b1;
        else m_pc <= m_pc + 8'd1;
      end
    end else if (m_awaiting) begin
      if (br_valid) begin
        m_awaiting <= 1'b0;
        m_pc <= br_taken ? m_word[7:0] : m_pc + 8'd1;
      end
    end else if (SkipNop && rom[m_pc] == 35'd0) begin
      m_pc <= m_pc + 8'd1;
    end else begin
      m_word    <= rom[m_pc];
      m_offered <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      check("pc", {27'd0, pc}, {27'd0, m_pc});
      check("rom_addr", {27'd0, rom_addr}, {27'd0, m_pc});
      check("instr_valid", {34'd0, instr_valid}, {34'd0, m_offered});
      check("fields", fields, m_word);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cycles, pulses;
    logic [7:0] acc_src;
    reset = 1'b1; instr_ready = 1'b1; br_valid = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 256; i++)
      rom[i] = mk(`MOV, 3'd0, 2'd1, 8'(i + 16), 2'd2, 8'(i + 32), 8'd0);
    rom[8]  = mk(`ATC, 3'd1, 2'd0, 8'd0, 2'd0, 8'd0, 8'd16);
    rom[12] = mk(`JMP, `UNC, 2'd0, 8'd0, 2'd0, 8'd0, 8'd4);
    rom[16] = mk(`JMP, `UNC, 2'd0, 8'd0, 2'd0, 8'd0, 8'd8);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; started = 1'b1;
    check("reset pc", {27'd0, pc}, 35'd0);
    check("reset valid", {34'd0, instr_valid}, 35'd0);
    check("reset fields", fields, 35'd0);

    // Sequential MOVs: one issue per two cycles.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq valid high", {34'd0, instr_valid}, 35'd1);
      check("seq src_val", {27'd0, src_val}, 35'(i + 16));
      check("seq dst_val", {27'd0, dst_val}, 35'(i + 32));
      tick();
      check("seq valid low", {34'd0, instr_valid}, 35'd0);
      check("seq pc step", {27'd0, pc}, 35'(i + 1));
    end
    tick_n(8);
    check("reach atc", {27'd0, pc}, 35'd8);

    // ATC at 8: wait with br_valid low, then taken to 16.
    tick();
    check("atc cmd", {31'd0, cmd}, {31'd0, `ATC});
    tick_n(6);
    check("wait pc", {27'd0, pc}, 35'd8);
    check("wait valid", {34'd0, instr_valid}, 35'd0);
    br_valid = 1'b1; br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    check("branch taken", {27'd0, pc}, 35'd16);
    tick_n(2);
    check("jmp back", {27'd0, pc}, 35'd8);
    tick_n(2);
    br_valid = 1'b1; br_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    check("branch not taken", {27'd0, pc}, 35'd9);
    tick_n(6);
    check("reach jmp", {27'd0, pc}, 35'd12);
    tick_n(2);
    check("jmp unc", {27'd0, pc}, 35'd4);

    // Back-pressure: instruction held while ready is low.
    instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall valid", {34'd0, instr_valid}, 35'd1);
      check("stall pc", {27'd0, pc}, 35'd4);
      check("stall src", {27'd0, src_val}, 35'h14);
    end
    instr_ready = 1'b1;
    tick();
    check("stall release", {27'd0, pc}, 35'd5);

    // PC wrap at 255.
    rom[5] = mk(`JMP, `UNC, 2'd0, 8'd0, 2'd0, 8'd0, 8'd255);
    tick_n(2);
    check("jump to 255", {27'd0, pc}, 35'd255);
    tick_n(2);
    check("pc wrap", {27'd0, pc}, 35'd0);

    // Asynchronous reset while waiting for a branch outcome.
    rom[1] = mk(`ATC, 3'd2, 2'd0, 8'd0, 2'd0, 8'd0, 8'd50);
    tick_n(5);
    check("pre-reset wait", {27'd0, pc}, 35'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset pc", {27'd0, pc}, {27'd0, ResetPc});
    check("async reset valid", {34'd0, instr_valid}, 35'd0);
    @(negedge clk);
    reset = 1'b0;

    // All-zero words at 1..3 followed by an ACC.
    rom[1] = '0; rom[2] = '0; rom[3] = '0;
    rom[4] = mk(`ACC, 3'd5, 2'd3, 8'hA5, 2'd1, 8'h5A, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cycles = 0; pulses = 0; acc_src = 8'd0;
    while (pc != 8'd5 && cycles < 40) begin
      tick();
      cycles++;
      if (instr_valid) begin
        pulses++;
        if (cmd == `ACC) acc_src = src_val;
      end
    end
    check("nop reach pc5", {27'd0, pc}, 35'd5);
    check("nop cycles", 35'(cycles), SkipNop ? 35'd7 : 35'd10);
    check("nop issues", 35'(pulses), SkipNop ? 35'd2 : 35'd5);
    check("acc fields", {27'd0, acc_src}, 35'hA5);

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] c;
      logic [2:0] o;
      case ($urandom_range(0, 4))
        0: c = 4'd0;
        1: c = `MOV;
        2: c = `ACC;
        3: c = `JMP;
        default: c = `ATC;
      endcase
      o = ($urandom_range(0, 1) == 0) ? `UNC : 3'($urandom);
      rom[i] = ($urandom_range(0, 7) == 0) ? 35'd0 :
               mk(c, o, 2'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      br_valid    = ($urandom_range(0, 9) < 3);
      br_taken    = 1'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1;
        check("rand async reset", {27'd0, pc}, {27'd0, ResetPc});
        @(negedge clk);
        reset = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
